adder_skew_feeder: RTL
======================

ADDER_SKEW_FEEDER -- requirements
Module: adder_skew_feeder

Interface
REQ-001 Parameter W, default 64: operand width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter TAGW, default 4: width of the transaction tag.
REQ-003 Derived N = W/8 SHALL be the lane count; lane i is bits [8i+7:8i].
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  operand set offered.
REQ-007 in_ready  out  1  feeder accepts an operand set this cycle.
REQ-008 in_a, in_b  in  W  operands; in_c  in  1  carry-in.
REQ-009 out_a, out_b  out  W  lane-skewed operands for the 8-bit-chunk registered adder.
REQ-010 out_c  out  1  carry-in, aligned with lane 0.
REQ-011 lane_vld  out  N  lane i of out_a/out_b holds a live transaction.
REQ-012 res_valid  out  1  adder result for the tagged transaction is complete.
REQ-013 res_tag  out  TAGW  tag of the completing transaction.
REQ-014 busy  out  1  at least one transaction in flight.

Function
REQ-015 Accept occurs on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 whenever resetn=1 (and flush=0 when compiled in); the feeder never back-pressures otherwise.
REQ-016 On accept at edge E, lane 0 of out_a/out_b and out_c SHALL present the operands after E; lane i SHALL present its slice after edge E+i (i-stage delay line per lane, registered outputs).
REQ-017 Lanes without a live transaction SHALL output 0 on out_a/out_b; out_c SHALL be 0 when lane_vld[0]=0.
REQ-018 lane_vld[0] SHALL be the registered accept; lane_vld[i] SHALL equal lane_vld[i-1] delayed one cycle.
REQ-019 res_valid SHALL pulse for one cycle after edge E+N (one cycle after lane_vld[N-1]), when the adder has captured lane N-1.
REQ-020 Tag counter (TAGW bits) SHALL start at 0, increment by one per accept, and wrap from 2^TAGW-1 to 0; each transaction carries its tag through a delay line to res_tag, which SHALL be 0 when res_valid=0.
REQ-021 Back-to-back accepts every cycle SHALL be supported; lanes then carry consecutive transactions with no gaps.
REQ-022 In-flight counter SHALL be incremented on accept, decremented on res_valid, unchanged on simultaneous accept and res_valid; range 0..N+1; busy = (counter != 0).
REQ-023 The feeder performs no arithmetic on operand values; slices pass unmodified.

Reset
REQ-024 With resetn=0 at an edge, all delay lines, lane_vld, res_valid, res_tag, tag counter and in-flight counter SHALL clear to 0; in_ready SHALL be 0 while resetn=0.
REQ-025 Reset mid-operation SHALL discard all in-flight transactions with no res_valid pulse; the first accept after reset carries tag 0.

Configuration
REQ-026 Macro ADDER_SKEW_FLUSH_EN: when defined, a port flush (in, 1) SHALL exist; flush=1 at an edge clears delay lines, lane_vld, res_valid and in-flight counter (tag counter retained), and in_ready SHALL be 0 during that cycle.
REQ-027 Without ADDER_SKEW_FLUSH_EN, no flush port exists and in_ready depends on resetn only.

Verification
REQ-028 Single accept a=0x00000000000000FF, b=0x01, c=0, W=64 -> lane i nonzero pattern appears after edge E+i, lane_vld walks 0x01..0x80, res_valid at E+8 with res_tag=0.
REQ-029 Eight back-to-back accepts -> lane_vld=0xFF steady, res_valid high eight consecutive cycles, res_tag 0..7 in order, busy falls after last res_valid.
REQ-030 Seventeen accepts with TAGW=4 -> 17th transaction returns res_tag=0 (wrap).
REQ-031 Feeder plus adder, a=0xFFFFFFFFFFFFFFFF, b=0, c=1 -> sum 0 with carry-out 1, full carry ripple across all 8 lanes correct.
REQ-032 resetn low for one cycle while 3 transactions in flight -> no res_valid afterwards, busy=0, next accept has tag 0.
REQ-033 With ADDER_SKEW_FLUSH_EN, flush while 2 in flight and in_valid=1 -> in_ready=0 that cycle, no res_valid, tag counter unchanged.

Source files
------------

// File: rtl/adder_skew_feeder.sv
// Lane-skewing operand feeder for an 8-bit-chunk registered ripple adder: lane i is delayed i+1 cycles.
// Optional flush port is compiled in with `define ADDER_SKEW_FLUSH_EN.
module adder_skew_feeder #(
    parameter int unsigned W    = 64,
    parameter int unsigned TAGW = 4
) (
    input  logic              clk,
    input  logic              resetn,
`ifdef ADDER_SKEW_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic              in_c,
    output logic [W-1:0]      out_a,
    output logic [W-1:0]      out_b,
    output logic              out_c,
    output logic [W/8-1:0]    lane_vld,
    output logic              res_valid,
    output logic [TAGW-1:0]   res_tag,
    output logic              busy
);

    localparam int unsigned N  = W / 8;
    localparam int unsigned CW = $clog2(N + 2);

    logic            clr;
    logic            accept;
    logic            c_q;
    logic [N-1:0]    vld_q;
    logic            res_q;
    logic [TAGW-1:0] tag_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TAGW-1:0] tag_pipe_q [N+1];

`ifdef ADDER_SKEW_FLUSH_EN
    assign clr      = !resetn || flush;
    assign in_ready = resetn && !flush;
`else
    assign clr      = !resetn;
    assign in_ready = resetn;
`endif

    assign accept = in_valid && in_ready;

    // Idle stages load zero, so lanes without a live transaction read as 0.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [7:0] a_q [i+1];
        logic [7:0] b_q [i+1];

        always_ff @(posedge clk) begin
            if (clr) begin
                for (int k = 0; k <= i; k++) begin
                    a_q[k] <= 8'h00;
                    b_q[k] <= 8'h00;
                end
            end else begin
                a_q[0] <= accept ? in_a[8*i +: 8] : 8'h00;
                b_q[0] <= accept ? in_b[8*i +: 8] : 8'h00;
                for (int k = 1; k <= i; k++) begin
                    a_q[k] <= a_q[k-1];
                    b_q[k] <= b_q[k-1];
                end
            end
        end

        assign out_a[8*i +: 8] = a_q[i];
        assign out_b[8*i +: 8] = b_q[i];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            c_q   <= 1'b0;
            vld_q <= '0;
            res_q <= 1'b0;
            cnt_q <= '0;
            for (int k = 0; k <= N; k++) begin
                tag_pipe_q[k] <= '0;
            end
        end else begin
            c_q           <= accept && in_c;
            vld_q         <= {vld_q[N-2:0], accept};
            res_q         <= vld_q[N-1];
            cnt_q         <= cnt_d;
            tag_pipe_q[0] <= accept ? tag_q : '0;
            for (int k = 1; k <= N; k++) begin
                tag_pipe_q[k] <= tag_pipe_q[k-1];
            end
        end
    end

    // Tag counter survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tag_q <= '0;
        end else if (accept) begin
            tag_q <= tag_q + TAGW'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !res_q) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept && res_q) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign out_c     = c_q;
    assign lane_vld  = vld_q;
    assign res_valid = res_q;
    assign res_tag   = tag_pipe_q[N];
    assign busy      = (cnt_q != '0);

endmodule
